// File: rtl/scan_decoder_n_if.sv
// Strobe-decoder bus: enable/mode/select in, strobes/index/wrap pulse out.
`timescale 1ns/1ps
interface scan_decoder_n_if #(
  parameter int SEL_W = 2
);
  localparam int NOUT = 1 << SEL_W;

  logic             G;
  logic             MODE;
  logic [SEL_W-1:0] SEL;
  logic [NOUT-1:0]  Y;
  logic [SEL_W-1:0] IDX;
  logic             WRAP;

  modport master (output G, MODE, SEL, input Y, IDX, WRAP);
  modport slave  (input G, MODE, SEL, output Y, IDX, WRAP);
endinterface

// File: rtl/scan_decoder_n.sv
// Registered N-to-2^N active-low decoder with direct-select and prescaled
// auto-scan modes; scan inserts one all-inactive blanking cycle per index.
`timescale 1ns/1ps
module scan_decoder_n #(
  parameter int SEL_W    = 2,
  parameter int PRESCALE = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  scan_decoder_n_if.slave  bus
);
  localparam int NOUT  = 1 << SEL_W;
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIRECT,
    S_DWELL,
    S_BLANK
  } state_t;

  function automatic logic [NOUT-1:0] f_strobe(input logic [SEL_W-1:0] idx);
    f_strobe = ~(NOUT'(1) << idx);
  endfunction

  state_t           r_state;
  logic [NOUT-1:0]  r_y;
  logic [SEL_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wrap;

  state_t           w_state_nxt;
  logic [NOUT-1:0]  w_y_nxt;
  logic [SEL_W-1:0] w_idx_nxt;
  logic [SEL_W-1:0] w_idx_inc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;

  assign w_idx_inc = r_idx + 1'b1;

  // Next-state and next-output decode; every output is the registered image
  // of the state being entered, so nothing here reaches a port directly.
  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = '1;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = '0;
    w_wrap_nxt  = 1'b0;
    if (bus.G) begin
      w_state_nxt = S_IDLE;
    end else if (!bus.MODE) begin
      w_state_nxt = S_DIRECT;
      w_y_nxt     = f_strobe(bus.SEL);
      w_idx_nxt   = bus.SEL;
    end else begin
      case (r_state)
        S_DWELL: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_BLANK;
          end else begin
            w_state_nxt = S_DWELL;
            w_cnt_nxt   = r_cnt + 1'b1;
            w_y_nxt     = f_strobe(r_idx);
          end
        end
        S_BLANK: begin
          w_state_nxt = S_DWELL;
          w_idx_nxt   = w_idx_inc;
          w_y_nxt     = f_strobe(w_idx_inc);
          w_wrap_nxt  = (r_idx == IDX_LAST);
        end
        default: begin
          // Entering scan from IDLE/DIRECT always restarts at index 0.
          w_state_nxt = S_DWELL;
          w_idx_nxt   = '0;
          w_y_nxt     = f_strobe('0);
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_y     <= '1;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign bus.Y    = r_y;
  assign bus.IDX  = r_idx;
  assign bus.WRAP = r_wrap;
endmodule

// File: tb/tb_scan_decoder_n.sv
// Bench for scan_decoder_n: two instances (SEL_W=2/PRESCALE=4, SEL_W=3/PRESCALE=1)
// checked against a frame-position reference model.
`timescale 1ns/1ps
module tb_scan_decoder_n;
  logic CLK;
  logic rst_a, rst_b;
  int   n_checks, n_fail;

  scan_decoder_n_if #(.SEL_W(2)) ifa ();
  scan_decoder_n_if #(.SEL_W(3)) ifb ();

  scan_decoder_n #(.SEL_W(2), .PRESCALE(4)) dut_a (.CLK(CLK), .RST_N(rst_a), .bus(ifa));
  scan_decoder_n #(.SEL_W(3), .PRESCALE(1)) dut_b (.CLK(CLK), .RST_N(rst_b), .bus(ifb));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: scan is described by a position within the frame
  // (NOUT*(PRESCALE+1) cycles); index and blanking follow by division.
  int         c_nout [2] = '{4, 8};
  int         c_ps   [2] = '{4, 1};
  bit         m_scan [2];
  int         m_pos  [2];
  logic [7:0] m_y    [2];
  int         m_idx  [2];
  bit         m_wrap [2];

  task automatic model_edge(input int u, input bit rn, input bit g, input bit mode, input int sel);
    int frame = c_nout[u] * (c_ps[u] + 1);
    m_wrap[u] = 1'b0;
    if (!rn) begin
      m_scan[u] = 1'b0; m_y[u] = 8'hFF; m_idx[u] = 0;
    end else if (g) begin
      m_scan[u] = 1'b0; m_y[u] = 8'hFF;
    end else if (!mode) begin
      m_scan[u] = 1'b0; m_y[u] = ~(8'd1 << sel); m_idx[u] = sel;
    end else if (!m_scan[u]) begin
      m_scan[u] = 1'b1; m_pos[u] = 0; m_idx[u] = 0; m_y[u] = 8'hFE;
    end else begin
      m_pos[u] = (m_pos[u] + 1) % frame;
      m_idx[u] = m_pos[u] / (c_ps[u] + 1);
      m_y[u]   = ((m_pos[u] % (c_ps[u] + 1)) == c_ps[u]) ? 8'hFF : ~(8'd1 << m_idx[u]);
      m_wrap[u] = (m_pos[u] == 0);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge(0, rst_a, ifa.G, ifa.MODE, int'(ifa.SEL));
    model_edge(1, rst_b, ifb.G, ifb.MODE, int'(ifb.SEL));
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; ifa.G = 1'b0; ifa.MODE = 1'b1; ifa.SEL = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({ifa.Y, ifa.IDX, ifa.WRAP} !== {4'b1111, 2'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_hold edge=%0d got Y=%b IDX=%0d WRAP=%b want Y=1111 IDX=0 WRAP=0", i, ifa.Y, ifa.IDX, ifa.WRAP);
      end
    end
    rst_a = 1'b1;
    tick();
    n_checks++;
    if ({ifa.Y, ifa.IDX, ifa.WRAP} !== {4'b1110, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release got Y=%b IDX=%0d WRAP=%b want Y=1110 IDX=0 WRAP=0", ifa.Y, ifa.IDX, ifa.WRAP);
    end
  endtask

  task automatic test_direct();
    logic [3:0] exp_y;
    ifa.MODE = 1'b0;
    for (int s = 0; s < 4; s++) begin
      ifa.SEL = 2'(s);
      tick();
      exp_y = ~(4'b0001 << s);
      n_checks++;
      if ({ifa.Y, ifa.IDX, ifa.WRAP} !== {exp_y, 2'(s), 1'b0}) begin
        n_fail++;
        $display("FAIL direct sel=%0d got Y=%b IDX=%0d WRAP=%b want Y=%b IDX=%0d WRAP=0", s, ifa.Y, ifa.IDX, ifa.WRAP, exp_y, s);
      end
    end
    ifa.G = 1'b1;
    tick();
    n_checks++;
    if ({ifa.Y, ifa.IDX} !== {4'b1111, 2'd3}) begin
      n_fail++;
      $display("FAIL direct_disable got Y=%b IDX=%0d want Y=1111 IDX=3", ifa.Y, ifa.IDX);
    end
  endtask

  task automatic test_scan();
    int n_wraps = 0;
    ifa.G = 1'b0; ifa.MODE = 1'b1;
    for (int k = 0; k < 45; k++) begin
      tick();
      n_checks++;
      if ({ifa.Y, ifa.IDX, ifa.WRAP} !== {m_y[0][3:0], 2'(m_idx[0]), m_wrap[0]}) begin
        n_fail++;
        $display("FAIL scan_seq k=%0d got Y=%b IDX=%0d WRAP=%b want Y=%b IDX=%0d WRAP=%b",
                 k, ifa.Y, ifa.IDX, ifa.WRAP, m_y[0][3:0], m_idx[0], m_wrap[0]);
      end
      if (ifa.WRAP === 1'b1) begin
        n_wraps++;
        n_checks++;
        if (ifa.Y !== 4'b1110 || (k % 20) != 0) begin
          n_fail++;
          $display("FAIL scan_wrap_pos k=%0d got Y=%b want Y=1110 at k multiple of 20", k, ifa.Y);
        end
      end
    end
    n_checks++;
    if (n_wraps != 2) begin
      n_fail++;
      $display("FAIL scan_wrap_count got %0d want 2", n_wraps);
    end
  endtask

  task automatic test_abort();
    ifa.G = 1'b1; tick();
    ifa.G = 1'b0; ifa.MODE = 1'b1; tick();
    repeat (11) tick();
    n_checks++;
    if ({ifa.Y, ifa.IDX} !== {4'b1011, 2'd2}) begin
      n_fail++;
      $display("FAIL abort_pre got Y=%b IDX=%0d want Y=1011 IDX=2", ifa.Y, ifa.IDX);
    end
    ifa.MODE = 1'b0; ifa.SEL = 2'd1; tick();
    n_checks++;
    if ({ifa.Y, ifa.IDX, ifa.WRAP} !== {4'b1101, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_direct got Y=%b IDX=%0d WRAP=%b want Y=1101 IDX=1 WRAP=0", ifa.Y, ifa.IDX, ifa.WRAP);
    end
    ifa.SEL = 2'd3; tick();
    n_checks++;
    if (ifa.Y !== 4'b0111) begin
      n_fail++;
      $display("FAIL abort_direct2 got Y=%b want Y=0111", ifa.Y);
    end
    ifa.MODE = 1'b1; tick();
    n_checks++;
    if ({ifa.Y, ifa.IDX, ifa.WRAP} !== {4'b1110, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_reentry got Y=%b IDX=%0d WRAP=%b want Y=1110 IDX=0 WRAP=0", ifa.Y, ifa.IDX, ifa.WRAP);
    end
    for (int k = 1; k < 20; k++) begin
      tick();
      n_checks++;
      if (ifa.WRAP !== 1'b0 || ifa.Y !== m_y[0][3:0]) begin
        n_fail++;
        $display("FAIL abort_nowrap k=%0d got Y=%b WRAP=%b want Y=%b WRAP=0", k, ifa.Y, ifa.WRAP, m_y[0][3:0]);
      end
    end
  endtask

  task automatic test_enable_reset();
    logic [3:0] exp_y;
    ifa.G = 1'b1; tick();
    ifa.G = 1'b0; ifa.MODE = 1'b1; tick();
    repeat (4) tick();
    n_checks++;
    if ({ifa.Y, ifa.IDX} !== {4'b1111, 2'd0}) begin
      n_fail++;
      $display("FAIL en_blank got Y=%b IDX=%0d want Y=1111 IDX=0", ifa.Y, ifa.IDX);
    end
    ifa.G = 1'b1; tick();
    n_checks++;
    if ({ifa.Y, ifa.IDX, ifa.WRAP} !== {4'b1111, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL en_disable got Y=%b IDX=%0d WRAP=%b want Y=1111 IDX=0 WRAP=0", ifa.Y, ifa.IDX, ifa.WRAP);
    end
    ifa.G = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_y = (k == 4) ? 4'b1111 : 4'b1110;
      n_checks++;
      if ({ifa.Y, ifa.IDX} !== {exp_y, 2'd0}) begin
        n_fail++;
        $display("FAIL en_restart k=%0d got Y=%b IDX=%0d want Y=%b IDX=0", k, ifa.Y, ifa.IDX, exp_y);
      end
    end
    repeat (12) tick();
    n_checks++;
    if ({ifa.Y, ifa.IDX} !== {4'b0111, 2'd3}) begin
      n_fail++;
      $display("FAIL rst_pre got Y=%b IDX=%0d want Y=0111 IDX=3", ifa.Y, ifa.IDX);
    end
    rst_a = 1'b0; tick();
    n_checks++;
    if ({ifa.Y, ifa.IDX, ifa.WRAP} !== {4'b1111, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_midscan got Y=%b IDX=%0d WRAP=%b want Y=1111 IDX=0 WRAP=0", ifa.Y, ifa.IDX, ifa.WRAP);
    end
    rst_a = 1'b1; tick();
    n_checks++;
    if ({ifa.Y, ifa.IDX, ifa.WRAP} !== {4'b1110, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_resume got Y=%b IDX=%0d WRAP=%b want Y=1110 IDX=0 WRAP=0", ifa.Y, ifa.IDX, ifa.WRAP);
    end
  endtask

  task automatic test_param_sweep();
    logic [7:0] exp_y;
    int         exp_idx;
    bit         exp_wrap;
    int         n_wraps = 0;
    rst_b = 1'b1; ifb.G = 1'b0; ifb.MODE = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      exp_idx  = (k / 2) % 8;
      exp_y    = (k % 2 == 1) ? 8'hFF : ~(8'd1 << exp_idx);
      exp_wrap = (k > 0) && (k % 16 == 0);
      if (ifb.WRAP === 1'b1) n_wraps++;
      n_checks++;
      if ({ifb.Y, ifb.IDX, ifb.WRAP} !== {exp_y, 3'(exp_idx), exp_wrap}) begin
        n_fail++;
        $display("FAIL sweep k=%0d got Y=%b IDX=%0d WRAP=%b want Y=%b IDX=%0d WRAP=%b",
                 k, ifb.Y, ifb.IDX, ifb.WRAP, exp_y, exp_idx, exp_wrap);
      end
      n_checks++;
      if ($countones(~ifb.Y) > 1) begin
        n_fail++;
        $display("FAIL sweep_onehot k=%0d got Y=%b want at most one low bit", k, ifb.Y);
      end
    end
    n_checks++;
    if (n_wraps != 2) begin
      n_fail++;
      $display("FAIL sweep_wrap_count got %0d want 2", n_wraps);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst_a = ($urandom_range(0, 59) != 0);
      rst_b = ($urandom_range(0, 59) != 0);
      ifa.G = ($urandom_range(0, 14) == 0);
      ifb.G = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 24) == 0) ifa.MODE = ~ifa.MODE;
      if ($urandom_range(0, 24) == 0) ifb.MODE = ~ifb.MODE;
      ifa.SEL = 2'($urandom);
      ifb.SEL = 3'($urandom);
      tick();
      n_checks++;
      if ({ifa.Y, ifa.IDX, ifa.WRAP} !== {m_y[0][3:0], 2'(m_idx[0]), m_wrap[0]}) begin
        n_fail++;
        $display("FAIL random_a k=%0d got Y=%b IDX=%0d WRAP=%b want Y=%b IDX=%0d WRAP=%b",
                 k, ifa.Y, ifa.IDX, ifa.WRAP, m_y[0][3:0], m_idx[0], m_wrap[0]);
      end
      n_checks++;
      if ({ifb.Y, ifb.IDX, ifb.WRAP} !== {m_y[1], 3'(m_idx[1]), m_wrap[1]}) begin
        n_fail++;
        $display("FAIL random_b k=%0d got Y=%b IDX=%0d WRAP=%b want Y=%b IDX=%0d WRAP=%b",
                 k, ifb.Y, ifb.IDX, ifb.WRAP, m_y[1], m_idx[1], m_wrap[1]);
      end
      n_checks++;
      if ($countones(~ifa.Y) > 1 || $countones(~ifb.Y) > 1) begin
        n_fail++;
        $display("FAIL random_onehot k=%0d got Ya=%b Yb=%b want at most one low bit each", k, ifa.Y, ifb.Y);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int u = 0; u < 2; u++) begin
      m_scan[u] = 1'b0; m_pos[u] = 0; m_y[u] = 8'hFF; m_idx[u] = 0; m_wrap[u] = 1'b0;
    end
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.G = 1'b1; ifa.MODE = 1'b0; ifa.SEL = '0;
    ifb.G = 1'b1; ifb.MODE = 1'b0; ifb.SEL = '0;
    test_reset();
    test_direct();
    test_scan();
    test_abort();
    test_enable_reset();
    test_param_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
